program_sequencer: RTL and testbench

Fetch stage that directly feeds the operand/opcode stage of the 8-bit CPU. It holds a small writable program store of ALU instruction words. Once started, it steps a program counter through the store and presents one decoded `a`, `b` and `alu_sel` triple per cycle under a valid/stall handshake. It stops on a halt word.

---
 rtl/program_sequencer.sv | 130 +++++++++++++
 tb/tb_program_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Fetch stage for the 8-bit CPU: a writable program store, stepped by a PC once started.
// Each cycle it presents one decoded (a, b, alu_sel) under a valid/stall handshake and stops on a halt word.
module program_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [19:0]   load_data,
    input  logic          start,
    input  logic          stall,
    output logic [7:0]    a,
    output logic [7:0]    b,
    output logic [2:0]    alu_sel,
    output logic          valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef struct packed {
        logic       halt;
        logic [2:0] alu_sel;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [2:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;

    instr_t        mem_q [DEPTH];
    instr_t        word_c;
    logic          slot_free_c;

    assign word_c      = mem_q[pc_q];
    assign slot_free_c = !valid_q || !stall;

    // Program store: not reset; writes are locked out while running or in reset.
    always_ff @(posedge clk) begin
        if (!rst && load_en && (state_q != RUN)) begin
            mem_q[load_addr] <= instr_t'(load_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        valid_d = valid_q;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                // A halt word retires the current output but leaves the operand bus as-is.
                if (slot_free_c) begin
                    if (word_c.halt) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else begin
                        a_d     = word_c.a;
                        b_d     = word_c.b;
                        sel_d   = word_c.alu_sel;
                        valid_d = 1'b1;
                        pc_d    = pc_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d   = (state_d == RUN);
        halted_d = (state_d == HALT);
    end

    assign a       = a_q;
    assign b       = b_q;
    assign alu_sel = sel_q;
    assign valid   = valid_q;
    assign pc      = pc_q;
    assign busy    = busy_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: the model walks its own copy of the store
// from address 0 to the first halt word and queues the expected instruction stream.
module tb_program_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst, load_en, start, stall;
    logic [AW-1:0] load_addr;
    logic [19:0]   load_data;
    logic [7:0]    a, b;
    logic [2:0]    alu_sel;
    logic          valid, busy, halted;
    logic [AW-1:0] pc;

    program_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall),
        .a(a), .b(b), .alu_sel(alu_sel), .valid(valid), .pc(pc),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] model_mem [DEPTH];
    bit          model_running = 0;
    logic [18:0] exp_q [$];
    int          halt_pc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: run the program from word 0, retiring one instruction per non-halt word.
    task automatic model_start();
        halt_pc = -1;
        for (int i = 0; i < 40; i++) begin
            logic [19:0] w;
            w = model_mem[i % DEPTH];
            if (w[19]) begin
                halt_pc = i % DEPTH;
                break;
            end
            exp_q.push_back(w[18:0]);
        end
        model_running = 1;
    endtask

    task automatic load(input int addr, input logic [19:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        if (!model_running) model_mem[addr] = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_start(input bit with_load, input int addr, input logic [19:0] data);
        start = 1'b1;
        if (with_load) begin
            load_en   = 1'b1;
            load_addr = AW'(addr);
            load_data = data;
            if (!model_running) model_mem[addr] = data;
        end
        model_start();
        tick();
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic do_reset(input bit with_load);
        rst = 1'b1;
        if (with_load) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = 20'h7_ABCD;
        end
        tick();
        rst     = 1'b0;
        load_en = 1'b0;
        stall   = 1'b0;
        exp_q.delete();
        model_running = 0;
        check("rst_a", 32'(a), 0);
        check("rst_b", 32'(b), 0);
        check("rst_sel", 32'(alu_sel), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
    endtask

    task automatic wait_halt(input bit rand_stall);
        for (int i = 0; i < 300 && !halted; i++) begin
            stall = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
        end
        stall = 1'b0;
        model_running = 0;
        check("halt_halted", 32'(halted), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_valid", 32'(valid), 0);
        check("halt_pc", 32'(pc), 32'(halt_pc));
        check("halt_queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic load_random_prog(input int hp);
        for (int i = 0; i < DEPTH; i++) begin
            logic [19:0] w;
            w     = 20'($urandom);
            w[19] = (i == hp) || ($urandom_range(0, 7) == 0);
            load(i, w);
        end
    endtask

    // Monitor: an output is consumed on an edge where it is valid and not stalled.
    logic [18:0] held_val;
    bit          hold_prev = 0;
    always @(negedge clk) begin
        if (hold_prev) begin
            check("stall_hold_valid", 32'(valid), 1);
            check("stall_hold_data", 32'({alu_sel, a, b}), 32'(held_val));
        end
        hold_prev = valid && stall && !rst;
        held_val  = {alu_sel, a, b};
        if (valid && !stall && !rst) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", 32'({alu_sel, a, b}), 32'h7FFFF);
            end else begin
                check("sb_output", 32'({alu_sel, a, b}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; start = 1'b0; stall = 1'b0;
        load_addr = '0; load_data = '0;
        tick();
        do_reset(0);

        // Basic program: two instructions then halt, no stall.
        load(0, {1'b0, 3'd0, 8'h05, 8'h03});
        load(1, {1'b0, 3'd1, 8'h10, 8'h02});
        load(2, {1'b1, 3'd0, 8'h00, 8'h00});
        do_start(0, 0, '0);
        check("e0_busy", 32'(busy), 1);
        check("e0_valid", 32'(valid), 0);
        tick();
        check("e1_valid", 32'(valid), 1);
        check("e1_data", 32'({alu_sel, a, b}), 32'({3'd0, 8'h05, 8'h03}));
        tick();
        check("e2_data", 32'({alu_sel, a, b}), 32'({3'd1, 8'h10, 8'h02}));
        tick();
        wait_halt(0);
        check("halt_keeps_a", 32'(a), 32'h10);

        // Same program with three stall cycles on the first output.
        do_start(0, 0, '0);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", 32'(pc), 1);
            check("stall_data", 32'({valid, alu_sel, a, b}), 32'({1'b1, 3'd0, 8'h05, 8'h03}));
        end
        stall = 1'b0;
        tick();
        check("post_stall_data", 32'({valid, alu_sel, a, b}), 32'({1'b1, 3'd1, 8'h10, 8'h02}));
        wait_halt(0);

        // No halt word: a = index, PC wraps 15 -> 0 and execution continues.
        for (int i = 0; i < DEPTH; i++) load(i, {1'b0, 3'($urandom), 8'(i), 8'($urandom)});
        do_start(0, 0, '0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                check("wrap_pc", 32'(pc), 0);
                check("wrap_a15", 32'(a), 15);
            end
            if (k == 17) check("wrap_a0", 32'(a), 0);
        end
        do_reset(0);

        // Reset mid-run while stalled (with a write discarded by reset), then replay.
        load_random_prog(9);
        model_mem[0][19] = 1'b0;
        load(0, model_mem[0]);
        do_start(0, 0, '0);
        for (int i = 0; i < 20 && !valid; i++) tick();
        stall = 1'b1;
        tick();
        tick();
        do_reset(1);
        do_start(0, 0, '0);
        wait_halt(1);

        // Writes during RUN are ignored; restart shows the original word 1.
        load(0, {1'b0, 3'd2, 8'h11, 8'h22});
        load(1, {1'b0, 3'd3, 8'h33, 8'h44});
        load(2, {1'b0, 3'd4, 8'h55, 8'h66});
        load(3, {1'b1, 19'h0});
        do_start(0, 0, '0);
        load(1, {1'b1, 3'd7, 8'hEE, 8'hFF});
        wait_halt(1);
        do_start(0, 0, '0);
        wait_halt(1);

        // In HALT: write word 0 together with start; the new word is fetched first.
        do_start(1, 0, {1'b0, 3'd6, 8'hA5, 8'h5A});
        tick();
        check("load_start_data", 32'({valid, alu_sel, a, b}), 32'({1'b1, 3'd6, 8'hA5, 8'h5A}));
        wait_halt(1);

        // Random programs with random stalls and ignored start pulses.
        for (int r = 0; r < 8; r++) begin
            load_random_prog($urandom_range(0, 12));
            do_start(0, 0, '0);
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_halt(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
